// File: rtl/cp0_irq_ctrl_if.sv
// CP0 register-access and exception-strobe bundle between the pipeline and cp0_irq_ctrl.
// The master side is the pipeline/interrupt sources; the slave side is CP0.
interface cp0_irq_ctrl_if;
  logic [5:0]  HWINT;
  logic [4:0]  ADD_I;
  logic        WE_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic [31:0] PC_I;
  logic        BD_I;
  logic [4:0]  EXCCODE_I;
  logic        EXL_SET;
  logic        EXL_CLR;
  logic [31:0] EPC_O;
  logic        INT_REQ;

  modport master (
    output HWINT, ADD_I, WE_I, DAT_I, PC_I, BD_I, EXCCODE_I, EXL_SET, EXL_CLR,
    input  DAT_O, EPC_O, INT_REQ
  );

  modport slave (
    input  HWINT, ADD_I, WE_I, DAT_I, PC_I, BD_I, EXCCODE_I, EXL_SET, EXL_CLR,
    output DAT_O, EPC_O, INT_REQ
  );
endinterface

// File: rtl/cp0_irq_ctrl.sv
// Coprocessor-0 interrupt/exception controller: SR/CAUSE/EPC/PRID, mfc0/mtc0 access,
// EPC capture on exception entry and the interrupt request towards the pipeline.
module cp0_irq_ctrl #(
  parameter logic [31:0] PRID_VAL = 32'h0000_7007,
  parameter logic [5:0]  IM_RST   = 6'b000000
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  cp0_irq_ctrl_if.slave  bus
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR.EXL doubles as the NORMAL/HANDLER mode bit.
  localparam logic NORMAL  = 1'b0;
  localparam logic HANDLER = 1'b1;

  logic [5:0]  im_q;
  logic        ie_q;
  logic        exl_q;
  logic [5:0]  ip_q;
  logic        bd_q;
  logic [4:0]  exc_code_q;
  logic [29:0] epc_q;

  logic sr_we;
  logic epc_we;

  assign sr_we  = bus.WE_I && (bus.ADD_I == REG_SR);
  assign epc_we = bus.WE_I && (bus.ADD_I == REG_EPC);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      im_q <= IM_RST;
      ie_q <= 1'b0;
    end else if (sr_we) begin
      im_q <= bus.DAT_I[15:10];
      ie_q <= bus.DAT_I[0];
    end
  end

  // Entry beats eret, and both strobes beat a software write of SR.EXL.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      exl_q <= NORMAL;
    end else if (bus.EXL_SET) begin
      exl_q <= HANDLER;
    end else if (bus.EXL_CLR) begin
      exl_q <= NORMAL;
    end else if (sr_we) begin
      exl_q <= bus.DAT_I[1];
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ip_q       <= 6'b0;
      bd_q       <= 1'b0;
      exc_code_q <= 5'b0;
      epc_q      <= 30'b0;
    end else begin
      ip_q <= bus.HWINT;
      if (bus.EXL_SET) begin
        bd_q       <= bus.BD_I;
        exc_code_q <= bus.EXCCODE_I;
        epc_q      <= bus.PC_I[31:2];
      end else if (epc_we) begin
        epc_q <= bus.DAT_I[31:2];
      end
    end
  end

  // The instruction address is word aligned; its low bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^bus.PC_I[1:0];

  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] epc_word;

  assign sr_word    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_word = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
  assign epc_word   = {epc_q, 2'b00};

  // NOTE: the default before the case keeps this mux purely combinational
  // for every ADD_I value, so no latch is inferred.
  always_comb begin
    bus.DAT_O = 32'b0;
    case (bus.ADD_I)
      REG_SR:    bus.DAT_O = sr_word;
      REG_CAUSE: bus.DAT_O = cause_word;
      REG_EPC:   bus.DAT_O = epc_word;
      REG_PRID:  bus.DAT_O = PRID_VAL;
      default:   bus.DAT_O = 32'b0;
    endcase
  end

  assign bus.EPC_O   = epc_word;
  assign bus.INT_REQ = (|(ip_q & im_q)) & ie_q & (exl_q == NORMAL);

endmodule
